// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the pipeline (decode/execute) and the
// iterative multiply/divide unit that owns HI/LO.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             read_request;
    logic             read_select;
    logic [WIDTH-1:0] read_value;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_valid, op, operand_a, operand_b, read_request, read_select,
        input  start_ready, read_value, stall, busy, hi, lo
    );

    modport slave (
        input  start_valid, op, operand_a, operand_b, read_request, read_select,
        output start_ready, read_value, stall, busy, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu unit owning HI/LO: WIDTH shift-add or
// restoring shift-subtract steps followed by one sign-fix cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [1:0]       op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] p_hi_q;
    logic [WIDTH-1:0] p_lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] step_hi_d;
    logic [WIDTH-1:0] step_lo_d;
    logic [WIDTH-1:0] fix_hi_d;
    logic [WIDTH-1:0] fix_lo_d;
    logic [2*WIDTH-1:0] prod_s;
    logic             b_zero_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // One iteration: multiply adds the multiplicand into the upper half and
    // shifts right; divide shifts the dividend into the partial remainder.
    always_comb begin
        sum_s     = {1'b0, p_hi_q} + {1'b0, opb_q};
        shifted_s = {p_hi_q, p_lo_q[WIDTH-1]};
        diff_s    = shifted_s[WIDTH-1:0] - opb_q;
        step_hi_d = p_hi_q;
        step_lo_d = p_lo_q;
        if (!op_q[1]) begin
            if (p_lo_q[0]) begin
                {step_hi_d, step_lo_d} = {sum_s, p_lo_q[WIDTH-1:1]};
            end else begin
                {step_hi_d, step_lo_d} = {1'b0, p_hi_q, p_lo_q[WIDTH-1:1]};
            end
        end else begin
            if (shifted_s >= {1'b0, opb_q}) begin
                step_hi_d = diff_s;
                step_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_d = shifted_s[WIDTH-1:0];
                step_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction of the magnitude result; divide-by-zero bypasses it.
    always_comb begin
        prod_s   = {p_hi_q, p_lo_q};
        b_zero_s = (opb_q == '0);
        fix_hi_d = p_hi_q;
        fix_lo_d = p_lo_q;
        case (op_q)
            2'b00: begin
                if (sign_a_q ^ sign_b_q) begin
                    {fix_hi_d, fix_lo_d} = ~prod_s + (2*WIDTH)'(1);
                end else begin
                    {fix_hi_d, fix_lo_d} = prod_s;
                end
            end
            2'b01: begin
                {fix_hi_d, fix_lo_d} = prod_s;
            end
            2'b10: begin
                if (b_zero_s) begin
                    fix_hi_d = a_raw_q;
                    fix_lo_d = '1;
                end else begin
                    fix_lo_d = (sign_a_q ^ sign_b_q) ? (~p_lo_q + WIDTH'(1)) : p_lo_q;
                    fix_hi_d = sign_a_q ? (~p_hi_q + WIDTH'(1)) : p_hi_q;
                end
            end
            2'b11: begin
                if (b_zero_s) begin
                    fix_hi_d = a_raw_q;
                    fix_lo_d = '1;
                end else begin
                    fix_hi_d = p_hi_q;
                    fix_lo_d = p_lo_q;
                end
            end
            default: begin
                fix_hi_d = p_hi_q;
                fix_lo_d = p_lo_q;
            end
        endcase
    end

    // Sequencer FSM and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_raw_q  <= '0;
            opb_q    <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        op_q     <= bus.op;
                        sign_a_q <= bus.operand_a[WIDTH-1] & ~bus.op[0];
                        sign_b_q <= bus.operand_b[WIDTH-1] & ~bus.op[0];
                        a_raw_q  <= bus.operand_a;
                        opb_q    <= magnitude(bus.operand_b, ~bus.op[0]);
                        p_hi_q   <= '0;
                        p_lo_q   <= magnitude(bus.operand_a, ~bus.op[0]);
                        count_q  <= '0;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    p_hi_q <= step_hi_d;
                    p_lo_q <= step_lo_d;
                    if (count_q == CW'(WIDTH-1)) begin
                        state_q <= FIX;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.stall       = bus.read_request && (state_q != IDLE);
    assign bus.read_value  = bus.read_select ? hi_q : lo_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected {hi,lo};
// a monitor compares whenever busy drops after a completed op.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();
    muldiv_sequencer #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: result and busy length checked on every completed op.
    initial begin : monitor
        bit prev_busy = 1'b0;
        bit prev_reset = 1'b1;
        int cnt = 0;
        logic [2*W-1:0] e;
        forever begin
            @(negedge clock);
            if (bus.busy === 1'b1) cnt++;
            if (prev_busy && bus.busy === 1'b0) begin
                if (!prev_reset) begin
                    check("busy_len", 64'(cnt), 64'd33);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got %h want none", {bus.hi, bus.lo});
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {bus.hi, bus.lo}, e);
                    end
                end
                cnt = 0;
            end
            prev_busy  = (bus.busy === 1'b1);
            prev_reset = (reset === 1'b1);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.start_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got busy want ready");
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] expv);
        wait_ready();
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clock);
        #1;
        bus.start_valid = 1'b0;
        wait_ready();
    endtask

    initial begin : stimulus
        int n;
        bus.start_valid  = 1'b0;
        bus.op           = 2'b00;
        bus.operand_a    = '0;
        bus.operand_b    = '0;
        bus.read_request = 1'b0;
        bus.read_select  = 1'b0;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.start_ready), 64'd1);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1);
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
        run_op(2'b11, 32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_op(2'b10, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF);
        run_op(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        run_op(2'b11, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF);
        run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);

        // Read of HI held from the accept cycle through the op (old HI = 1).
        bus.op = 2'b01;
        bus.operand_a = 32'h00010000;
        bus.operand_b = 32'h00030000;
        bus.start_valid = 1'b1;
        bus.read_request = 1'b1;
        bus.read_select = 1'b1;
        exp_q.push_back(64'h00000003_00000000);
        #1;
        check("stall_idle_read", 64'(bus.stall), 64'd0);
        check("old_hi_read", 64'(bus.read_value), 64'd1);
        @(posedge clock);
        #1 bus.start_valid = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (bus.stall !== 1'b1) break;
            n++;
        end
        check("stall_len", 64'(n), 64'd33);
        check("read_after_stall", 64'(bus.read_value), 64'd3);
        bus.read_request = 1'b0;
        bus.read_select = 1'b0;

        // Reset in the middle of an op: aborted, no result expected.
        wait_ready();
        bus.op = 2'b01;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd9;
        bus.start_valid = 1'b1;
        @(posedge clock);
        #1 bus.start_valid = 1'b0;
        repeat (11) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_ready", 64'(bus.start_ready), 64'd1);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        run_op(2'b01, 32'd6, 32'd7, 64'd42);

        // start_valid held across a busy op: second accept only after FIX.
        wait_ready();
        bus.op = 2'b01;
        bus.operand_a = 32'd2;
        bus.operand_b = 32'd3;
        bus.start_valid = 1'b1;
        exp_q.push_back(64'd6);
        @(posedge clock);
        #1;
        bus.op = 2'b11;
        bus.operand_a = 32'd50;
        bus.operand_b = 32'd7;
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (bus.start_ready === 1'b1) break;
            n++;
        end
        check("held_wait", 64'(n), 64'd33);
        exp_q.push_back(64'h00000001_00000007);
        @(posedge clock);
        #1 bus.start_valid = 1'b0;
        check("held_accept", 64'(bus.busy), 64'd1);
        wait_ready();

        repeat (2) @(negedge clock);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
